// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-command APB initiator with registered outputs.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Last ACCESS cycle index that may still wait for pready.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0]            cnt_q;
  logic                  rsp_timeout_q;
`else
  logic                  unused_timeout;
  assign unused_timeout = |TO_LAST;
`endif

  // Transfer FSM; every bus and response output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= SETUP;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            rsp_err_q   <= pslverr;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vectors for apb_master_bridge.
// Timeout vectors run only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hAAAA_5555;
    cmd_wdata = 32'h5555_AAAA;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] hist;
    int         acc_at [3];
    int         nacc;
    logic       any_rsp;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    rst = 1'b0;
    step();

    // zero-wait write
    pready = 1'b1;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("wr_setup_psel", 64'(psel), 64'(1));
    chk("wr_setup_pen", 64'(penable), 64'(0));
    chk("wr_setup_rdy", 64'(cmd_ready), 64'(0));
    chk("wr_setup_paddr", 64'(paddr), 64'h10);
    chk("wr_setup_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("wr_setup_pwrite", 64'(pwrite), 64'(1));
    step();
    chk("wr_acc_pen", 64'(penable), 64'(1));
    chk("wr_acc_paddr", 64'(paddr), 64'h10);
    chk("wr_acc_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("wr_acc_rspv", 64'(rsp_valid), 64'(0));
    step();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("wr_rsp_err", 64'(rsp_err), 64'(0));
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("wr_done_psel", 64'(psel), 64'(0));
    chk("wr_done_pen", 64'(penable), 64'(0));
    chk("wr_done_rdy", 64'(cmd_ready), 64'(1));
    chk("wr_hold_paddr", 64'(paddr), 64'h10);
    step();
    chk("wr_rsp_drop", 64'(rsp_valid), 64'(0));

    // read with two wait states
    pready = 1'b0;
    prdata = 32'h0BAD_F00D;
    issue(1'b0, 32'h10, 32'h0);
    chk("rd_setup_psel", 64'(psel), 64'(1));
    chk("rd_setup_pen", 64'(penable), 64'(0));
    step();
    chk("rd_acc1_pen", 64'(penable), 64'(1));
    step();
    chk("rd_acc2_pen", 64'(penable), 64'(1));
    chk("rd_acc2_paddr", 64'(paddr), 64'h10);
    chk("rd_acc2_rspv", 64'(rsp_valid), 64'(0));
    step();
    chk("rd_acc3_pen", 64'(penable), 64'(1));
    chk("rd_acc3_rspv", 64'(rsp_valid), 64'(0));
    chk("rd_acc3_pwrite", 64'(pwrite), 64'(0));
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    step();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    chk("rd_rsp_err", 64'(rsp_err), 64'(0));
    chk("rd_done_psel", 64'(psel), 64'(0));
    step();
    chk("rd_rdata_zero", 64'(rsp_rdata), 64'(0));

    // slave error
    pslverr = 1'b1;
    prdata  = 32'h1234_5678;
    issue(1'b0, 32'hFFFF_0000, 32'h0);
    step();
    step();
    chk("err_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("err_rsp_err", 64'(rsp_err), 64'(1));
    chk("err_rsp_tmo", 64'(rsp_timeout), 64'(0));
    chk("err_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
    chk("err_psel", 64'(psel), 64'(0));
    pslverr = 1'b0;
    step();
    chk("err_clear", 64'(rsp_err), 64'(0));

    // back-to-back writes
    nacc      = 0;
    hist      = '0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h100;
    cmd_wdata = 32'h1;
    for (int i = 0; i < 9; i++) begin
      logic take;
      take = cmd_valid && cmd_ready;
      step();
      hist[i] = psel;
      if (take) begin
        acc_at[nacc] = i;
        nacc++;
        cmd_addr  = cmd_addr + 32'h4;
        cmd_wdata = cmd_wdata + 32'h1;
        if (nacc == 3) cmd_valid = 1'b0;
      end
    end
    chk("b2b_nacc", 64'(nacc), 64'(3));
    chk("b2b_acc0", 64'(acc_at[0]), 64'(0));
    chk("b2b_acc1", 64'(acc_at[1]), 64'(3));
    chk("b2b_acc2", 64'(acc_at[2]), 64'(6));
    chk("b2b_psel_hist", 64'(hist), 64'h0DB);
    chk("b2b_last_paddr", 64'(paddr), 64'h108);
    chk("b2b_last_pwdata", 64'(pwdata), 64'h3);

`ifdef APB_MASTER_TIMEOUT_EN
    // stuck slave, abort after four ACCESS cycles
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    issue(1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tmo_acc_pen", 64'(penable), 64'(1));
    end
    step();
    chk("tmo_psel", 64'(psel), 64'(0));
    chk("tmo_pen", 64'(penable), 64'(0));
    chk("tmo_rspv", 64'(rsp_valid), 64'(1));
    chk("tmo_err", 64'(rsp_err), 64'(1));
    chk("tmo_tmo", 64'(rsp_timeout), 64'(1));
    chk("tmo_rdata", 64'(rsp_rdata), 64'(0));
    step();

    // pready in the last counted cycle wins
    issue(1'b0, 32'h24, 32'h0);
    for (int i = 0; i < 4; i++) step();
    pready = 1'b1;
    prdata = 32'h00C0_FFEE;
    step();
    chk("tmo_win_rspv", 64'(rsp_valid), 64'(1));
    chk("tmo_win_tmo", 64'(rsp_timeout), 64'(0));
    chk("tmo_win_err", 64'(rsp_err), 64'(0));
    chk("tmo_win_rdata", 64'(rsp_rdata), 64'h00C0_FFEE);
    step();
`endif

    // reset during the 2nd ACCESS cycle of a read
    pready = 1'b0;
    issue(1'b0, 32'h30, 32'h0);
    step();
    step();
    chk("rr_acc2_pen", 64'(penable), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_psel", 64'(psel), 64'(0));
    chk("rr_pen", 64'(penable), 64'(0));
    chk("rr_paddr", 64'(paddr), 64'(0));
    chk("rr_pwrite", 64'(pwrite), 64'(0));
    chk("rr_rspv", 64'(rsp_valid), 64'(0));
    chk("rr_rdy", 64'(cmd_ready), 64'(1));
    pready  = 1'b1;
    any_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      any_rsp = any_rsp | rsp_valid | psel;
    end
    chk("rr_no_rsp", 64'(any_rsp), 64'(0));
    chk("rr_rdy_after", 64'(cmd_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator for the APB SRAM subsystem: accepts single read/write commands on a valid/ready request port and issues them as APB SETUP/ACCESS transfers to the SRAM slave. It returns read data, slave error and timeout status on a one-cycle response strobe. It sits between the test-side or CPU-side command source and the `apb_inf` bus. Its bus behaviour satisfies the read, write and error sequence properties enforced on that interface.

## Interface
- `ADDR_WIDTH`, default 32: APB address width (matches `` `ADDR_WIDTH ``).
- `DATA_WIDTH`, default 32: APB data width (matches `` `DATA_WIDTH ``).
- `TIMEOUT_CYCLES`, default 16: ACCESS-phase cycles allowed without `pready`. Range 1..255. Used only with the timeout feature.
- Clocking and reset (already decided): one clock, `clk`. Reset `rst` is synchronous and active-high.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: bridge can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: transfer address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_rdata` out DATA_WIDTH: read data. 0 for writes and timeouts.
- `rsp_err` out 1: `pslverr` sampled at completion, or timeout.
- `rsp_timeout` out 1: completion caused by timeout.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_WIDTH: APB address.
- `pwdata` out DATA_WIDTH: APB write data.
- `prdata` in DATA_WIDTH: APB read data.
- `pready`, `pslverr` in 1: APB slave handshake and error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `cmd_ready`=1; `psel`=`penable`=0.
  - On `cmd_valid && cmd_ready`, register `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata` and go to SETUP.
- SETUP: `psel`=1, `penable`=0, `cmd_ready`=0. Always advance to ACCESS.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=1: capture `prdata` (reads only, else 0) and `pslverr`, then go to IDLE. `rsp_valid`=1 in the following cycle.
  - `pready`=0: stay in ACCESS. `paddr`/`pwrite`/`pwdata` are stable for the whole transfer.
- `psel` is always low for at least one cycle between transfers: after completion, `penable` and `psel` drop together.
- `paddr`/`pwdata`/`pwrite` hold their last values in IDLE.
- `rsp_*` fields are valid only while `rsp_valid`=1 and are 0 otherwise.
- A command accepted in the same cycle as a `rsp_valid` strobe is legal.
- Reset:
  - All outputs reset to 0, except `cmd_ready`, which is 1 from the first cycle after reset.
  - Reset asserted mid-transfer abandons it: bus idle next cycle, no response issued.

## Timing
- Accept at edge T → SETUP cycle T+1 → first ACCESS cycle T+2.
- `pready` high in the ACCESS cycle ending at edge N → `rsp_valid` in cycle N+1, bus idle in N+1, `cmd_ready` high in N+1.
- Zero wait states: 3 cycles per transfer, accept to accept.
- W wait states: 3+W cycles per transfer.
- No combinational path from `cmd_*` to any APB output, or from `pready`/`prdata` to `rsp_*`.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with `pready`=0.
  - If the counter reaches `TIMEOUT_CYCLES` with `pready` still 0, the transfer aborts: IDLE next cycle with `psel`=`penable`=0.
  - The abort produces `rsp_valid`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - `pready`=1 in the final counted cycle wins over the timeout.
- `APB_MASTER_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely; `rsp_timeout` is tied 0.

## Test plan
- Write 0x10 ← 0xDEADBEEF, `pready` high in the first ACCESS cycle:
  - `psel` rises at T+1, `penable` at T+2.
  - `rsp_valid` at T+3 with `rsp_err`=0.
  - `paddr`=0x10 and `pwdata`=0xDEADBEEF throughout the transfer.
- Read 0x10, slave inserts 2 wait states and returns `prdata`=0xDEADBEEF:
  - ACCESS lasts 3 cycles.
  - `rsp_rdata`=0xDEADBEEF at T+5.
  - `paddr` stable throughout.
- Read an out-of-range address with `pslverr`=1 alongside `pready`: `rsp_err`=1, `rsp_timeout`=0, `psel` low in the next cycle.
- Back-to-back: `cmd_valid` held high for 3 writes at zero wait states:
  - Accepts at T, T+3, T+6.
  - `psel` low for exactly one cycle between transfers.
- With `APB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `pready` stuck 0: after 4 ACCESS cycles the bus drops, and `rsp_valid`/`rsp_err`/`rsp_timeout` are all 1.
- `rst` pulsed during the 2nd ACCESS cycle of a read:
  - Next cycle all outputs 0, `rsp_valid` never pulses.
  - `cmd_ready`=1 after reset release.
